instr_decoder: RTL and testbench
================================

# instr_decoder

Decodes 16-bit instruction words into the per-instruction control bundle consumed by the register file / ALU datapath: one-hot register write enable, flag enable, register-or-immediate select, opcode, source/destination register numbers and extended immediate. It sits between instruction fetch and the datapath. It replaces the hard-wired test sequencers with real decode, behind a one-stage valid/ready pipeline register. An illegal encoding halts the block until reset.

## Interface
- No parameters; data widths are fixed by the ISA (16-bit word, 16 registers).
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  in_instr holds a valid word
- in_instr  in  16  instruction word: [15:12] op, [11:8] Rdest, [7:4] ext/imm-hi, [3:0] Rsrc/imm-lo
- in_ready  out  1  block accepts in_instr this cycle
- out_valid  out  1  control bundle valid
- out_ready  in  1  datapath consumes the bundle this cycle
- regEnable  out  16  one-hot write enable, bit = Rdest
- flagEn  out  1  update PSR flags
- RorI  out  1  1 = immediate operand, 0 = register operand
- opcode  out  8  {in_instr[15:12], in_instr[7:4]}
- Rsrc, Rdest  out  4 each  register numbers
- imm  out  16  extended immediate
- out_illegal  out  1  bundle is an illegal encoding
- halted  out  1  block is in HALT
- issue_count  out  16  legal bundles consumed since reset

## Operation
- Register-type words (op=0000): ext selects the operation.
  - 0001 AND, 0010 OR, 0011 XOR
  - 0101 ADD, 0110 ADDU, 0111 ADDC
  - 1001 SUB, 1010 SUBC, 1011 CMP
  - 1101 MOV, 1110 MUL
  - RorI=0, Rsrc=in[3:0], imm=0.
- Immediate-type words: op ∈ {0001,0010,0011,0101,0110,0111,1001,1010,1011,1101,1110}.
  - RorI=1, Rsrc=0, 8-bit immediate = in[7:0].
  - Sign-extended to 16 bits for ADDI, ADDCI, SUBI, SUBCI, CMPI, MOVI, MULI.
  - Zero-extended for ANDI, ORI, XORI, ADDUI.
- Shift words (op=1000), compiled per Configuration:
  - ext 1000 LSH, ext 1111 ASHU: RorI=0.
  - ext 000s LSHI, ext 001s ASHUI: RorI=1, imm = sign-extend of {s, in[3:0]} (5 bits).
- flagEn=1 for ADD/ADDU/ADDC/SUB/SUBC/CMP/MUL and their immediate forms; 0 for logic, MOV and shift operations.
- regEnable = 1<<Rdest, except CMP/CMPI and illegal words, which give 0.
- Every other encoding is illegal: out_illegal=1, regEnable=0, flagEn=0, RorI=0, imm=0; opcode, Rsrc and Rdest remain raw fields.
- regEnable and flagEn are forced to 0 whenever out_valid=0.
- State machine:
  - EMPTY: no bundle held.
  - FULL: bundle held.
  - HALT: entered after an illegal bundle is consumed.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on simultaneous consume+accept.
  - FULL→EMPTY on consume without accept.
  - FULL→HALT when the consumed bundle is illegal; no accept occurs that cycle.
  - HALT exits only on rst.
- in_ready = !rst && state≠HALT && (state==EMPTY || (out_ready && !out_illegal)).
- issue_count increments on each consume with out_illegal=0 and wraps 0xFFFF→0x0000.

## Timing
- Reset values: state EMPTY, out_valid=0, regEnable=0, flagEn=0, RorI=0, opcode=0, Rsrc=0, Rdest=0, imm=0, out_illegal=0, halted=0, issue_count=0. in_ready=0 while rst is high and 1 the cycle after.
- Accept = in_valid && in_ready; consume = out_valid && out_ready.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one word per cycle when out_ready is held high.
- Under backpressure (out_valid && !out_ready) all outputs hold stable; no word is dropped or duplicated.
- rst mid-operation discards the held bundle; rst in HALT returns the block to EMPTY.
- halted=1 from the cycle after the illegal bundle is consumed.

## Configuration
- INSTR_DEC_SHIFT_EN defined: shift words decode as given in Operation.
- INSTR_DEC_SHIFT_EN undefined: every op=1000 word is illegal and halts the block.

## Test plan
- MOVI R2,20 (0xD214) → opcode 0xD1, Rdest 2, imm 0x0014, RorI 1, regEnable 0x0004, flagEn 0, issue_count 1 after consume.
- MUL R1,R2 (0x01E2) → opcode 0x0E, Rdest 1, Rsrc 2, RorI 0, regEnable 0x0002, flagEn 1.
- ADDI R3,-1 (0x53FF) → imm 0xFFFF; ANDI R4,0xFF (0x14FF) → imm 0x00FF, flagEn 0; CMPI R5,3 (0xB503) → regEnable 0, flagEn 1.
- Back-to-back stream of 4 words with out_ready low for 3 cycles mid-stream → outputs stable while stalled, in_ready low, all 4 bundles delivered in order.
- 0x0004 (undefined ext) → out_illegal 1, regEnable 0; after consume halted=1, in_ready=0 and out_valid=0 until rst; after rst, 0xD214 decodes normally.
- LSHI R1,-2 (0x811E) → with macro: RorI 1, imm 0xFFFE, regEnable 0x0002; without macro: out_illegal 1.

Source files
------------

// File: rtl/instr_decoder.sv
// Decodes 16-bit ISA words into the datapath control bundle behind a one-stage valid/ready register.
// Define INSTR_DEC_SHIFT_EN to decode op=1000 shift words; otherwise they are illegal and halt the block.
module instr_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] in_instr,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] regEnable,
   output logic        flagEn,
   output logic        RorI,
   output logic [7:0]  opcode,
   output logic [3:0]  Rsrc,
   output logic [3:0]  Rdest,
   output logic [15:0] imm,
   output logic        out_illegal,
   output logic        halted,
   output logic [15:0] issue_count
);

   // Handshake: a word moves on accept = in_valid && in_ready; the bundle leaves on
   // consume = out_valid && out_ready. An illegal bundle blocks accept in its consume cycle.
   typedef enum logic [1:0] {EMPTY, FULL, HALT} state_t;
   state_t state;

   logic [3:0]  op;
   logic [3:0]  ext;
   logic        d_legal;
   logic        d_wr;
   logic        d_flag;
   logic        d_rori;
   logic [3:0]  d_rsrc;
   logic [15:0] d_imm;
   logic        accept;
   logic        consume;

   always_comb begin
      op      = in_instr[15:12];
      ext     = in_instr[7:4];
      d_legal = 1'b0;
      d_wr    = 1'b0;
      d_flag  = 1'b0;
      d_rori  = 1'b0;
      d_rsrc  = in_instr[3:0];
      d_imm   = 16'h0000;
      if (op == 4'b0000) begin
         case (ext)
            4'b0001, 4'b0010, 4'b0011, 4'b1101: begin
               d_legal = 1'b1;
               d_wr    = 1'b1;
            end
            4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1110: begin
               d_legal = 1'b1;
               d_wr    = 1'b1;
               d_flag  = 1'b1;
            end
            4'b1011: begin
               d_legal = 1'b1;
               d_flag  = 1'b1;
            end
            default: d_legal = 1'b0;
         endcase
      end else if (op == 4'b1000) begin
`ifdef INSTR_DEC_SHIFT_EN
         case (ext)
            4'b1000, 4'b1111: begin
               d_legal = 1'b1;
               d_wr    = 1'b1;
            end
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
               d_legal = 1'b1;
               d_wr    = 1'b1;
               d_rori  = 1'b1;
               d_rsrc  = 4'h0;
               d_imm   = {{11{ext[0]}}, ext[0], in_instr[3:0]};
            end
            default: d_legal = 1'b0;
         endcase
`else
         d_legal = 1'b0;
`endif
      end else begin
         case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b0110: begin
               // logic ops and ADDUI take a zero-extended immediate
               d_legal = 1'b1;
               d_wr    = 1'b1;
               d_flag  = (op == 4'b0110);
               d_rori  = 1'b1;
               d_rsrc  = 4'h0;
               d_imm   = {8'h00, in_instr[7:0]};
            end
            4'b0101, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110: begin
               d_legal = 1'b1;
               d_wr    = (op != 4'b1011);
               d_flag  = (op != 4'b1101);
               d_rori  = 1'b1;
               d_rsrc  = 4'h0;
               d_imm   = {{8{in_instr[7]}}, in_instr[7:0]};
            end
            default: d_legal = 1'b0;
         endcase
      end
   end

   assign in_ready = !rst && (state != HALT) &&
                     ((state == EMPTY) || (out_ready && !out_illegal));
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         out_valid   <= 1'b0;
         regEnable   <= 16'h0000;
         flagEn      <= 1'b0;
         RorI        <= 1'b0;
         opcode      <= 8'h00;
         Rsrc        <= 4'h0;
         Rdest       <= 4'h0;
         imm         <= 16'h0000;
         out_illegal <= 1'b0;
         halted      <= 1'b0;
         issue_count <= 16'h0000;
      end else begin
         if (consume && !out_illegal)
            issue_count <= issue_count + 16'd1;
         if (accept) begin
            state       <= FULL;
            out_valid   <= 1'b1;
            regEnable   <= d_wr ? (16'h0001 << in_instr[11:8]) : 16'h0000;
            flagEn      <= d_flag;
            RorI        <= d_rori;
            opcode      <= {op, ext};
            Rsrc        <= d_rsrc;
            Rdest       <= in_instr[11:8];
            imm         <= d_imm;
            out_illegal <= !d_legal;
         end else if (consume) begin
            // fields other than the enables keep their last values once the bundle leaves
            state     <= out_illegal ? HALT : EMPTY;
            halted    <= out_illegal;
            out_valid <= 1'b0;
            regEnable <= 16'h0000;
            flagEn    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed vector table, hand sequences and a
// randomized stream scored against a mnemonic-level reference model.
module tb_instr_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] regEnable;
   logic        flagEn;
   logic        RorI;
   logic [7:0]  opcode;
   logic [3:0]  Rsrc;
   logic [3:0]  Rdest;
   logic [15:0] imm;
   logic        out_illegal;
   logic        halted;
   logic [15:0] issue_count;

   instr_decoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .regEnable(regEnable), .flagEn(flagEn),
      .RorI(RorI), .opcode(opcode), .Rsrc(Rsrc), .Rdest(Rdest), .imm(imm),
      .out_illegal(out_illegal), .halted(halted), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        illegal;
      logic [15:0] reg_en;
      logic        flag;
      logic        rori;
      logic [7:0]  opcode;
      logic [3:0]  rsrc;
      logic [3:0]  rdest;
      logic [15:0] imm;
   } bundle_t;

   typedef struct {
      logic [15:0] instr;
      bundle_t     exp;
   } vec_t;

   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_issue = 0;
   string       mnem [16];
   vec_t        vecs [8];
   logic [15:0] src_q[$];
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pack(input bundle_t b);
      return {13'b0, b.illegal, b.reg_en, b.flag, b.rori, b.opcode, b.rsrc, b.rdest, b.imm};
   endfunction

   function automatic logic [63:0] pack_out();
      return {13'b0, out_illegal, regEnable, flagEn, RorI, opcode, Rsrc, Rdest, imm};
   endfunction

   function automatic bundle_t mk(input logic il, input logic [15:0] re, input logic fl,
                                  input logic ri, input logic [7:0] oc, input logic [3:0] rs,
                                  input logic [3:0] rd, input logic [15:0] im);
      bundle_t b;
      b.illegal = il; b.reg_en = re; b.flag = fl; b.rori = ri;
      b.opcode = oc; b.rsrc = rs; b.rdest = rd; b.imm = im;
      return b;
   endfunction

   function automatic logic is_arith(input string mn);
      return mn == "ADD" || mn == "ADDU" || mn == "ADDC" || mn == "SUB" ||
             mn == "SUBC" || mn == "CMP" || mn == "MUL";
   endfunction

   // Reference: name the instruction, then derive every control field from its name.
   function automatic bundle_t model(input logic [15:0] w);
      bundle_t    b;
      string      mn;
      int         kind;
      int         v;
      logic [3:0] op;
      logic [3:0] ext;
      op = w[15:12];
      ext = w[7:4];
      b = mk(1'b1, 16'h0, 1'b0, 1'b0, {op, ext}, w[3:0], w[11:8], 16'h0);
      mn = "";
      kind = -1;
      if (op == 4'h0 && mnem[ext] != "") begin
         mn = mnem[ext]; kind = 0;
      end else if (op == 4'h8) begin
`ifdef INSTR_DEC_SHIFT_EN
         if (ext == 4'h8) begin mn = "LSH"; kind = 0; end
         else if (ext == 4'hF) begin mn = "ASHU"; kind = 0; end
         else if (ext < 4) begin mn = (ext < 2) ? "LSHI" : "ASHUI"; kind = 2; end
`endif
      end else if (op != 4'h0 && mnem[op] != "") begin
         mn = mnem[op]; kind = 1;
      end
      if (kind >= 0) begin
         b.illegal = 1'b0;
         b.flag = is_arith(mn);
         b.rori = (kind != 0);
         if (b.rori) b.rsrc = 4'h0;
         if (kind == 1) begin
            v = int'(w[7:0]);
            if (!(mn == "AND" || mn == "OR" || mn == "XOR" || mn == "ADDU") && v >= 128) v -= 256;
            b.imm = v[15:0];
         end
         if (kind == 2) begin
            v = (ext[0] ? 16 : 0) + int'(w[3:0]);
            if (v >= 16) v -= 32;
            b.imm = v[15:0];
         end
         v = 1 << b.rdest;
         b.reg_en = (mn == "CMP") ? 16'h0 : v[15:0];
      end
      return b;
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = 16'h0;
      @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_bundle", pack_out(), 64'h0);
      check("rst_halted", halted, 0);
      check("rst_issue_count", issue_count, 0);
      rst = 1'b0;
      exp_issue = 0;
      #1;
      check("post_rst_in_ready", in_ready, 1);
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      @(negedge clk);
      in_valid = 1'b1; in_instr = v.instr; out_ready = 1'b0;
      #1;
      check({name, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check({name, "_out_valid"}, out_valid, 1);
      check(name, pack_out(), pack(v.exp));
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      out_ready = 1'b0;
      if (!v.exp.illegal) exp_issue++;
      check({name, "_drained"}, {out_valid, regEnable, flagEn}, 18'h0);
      check({name, "_issue_count"}, issue_count, exp_issue[15:0]);
   endtask

   task automatic illegal_seq(input logic [15:0] w, input string name);
      @(negedge clk);
      in_valid = 1'b1; in_instr = w; out_ready = 1'b0;
      @(negedge clk);
      in_instr = 16'hD214;
      out_ready = 1'b1;
      #1;
      check({name, "_bundle"}, pack_out(),
            pack(mk(1'b1, 16'h0, 1'b0, 1'b0, {w[15:12], w[7:4]}, w[3:0], w[11:8], 16'h0)));
      check({name, "_no_accept"}, in_ready, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check({name, "_halted"}, halted, 1);
         check({name, "_halt_out_valid"}, out_valid, 0);
         check({name, "_halt_in_ready"}, in_ready, 0);
      end
      check({name, "_issue_count"}, issue_count, exp_issue[15:0]);
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   // mode 0: out_ready low for cycles 2..4; mode 1: random out_ready
   task automatic run_words(input int mode, input string name);
      int          idx = 0;
      int          cyc = 0;
      logic        stalled_prev = 1'b0;
      logic [63:0] snap = 64'h0;
      bundle_t     e;
      exp_q.delete();
      while ((idx < src_q.size() || exp_q.size() > 0) && cyc < 3000) begin
         out_ready = (mode == 0) ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(0, 3) != 0);
         if (idx < src_q.size()) begin
            in_valid = 1'b1; in_instr = src_q[idx];
         end else begin
            in_valid = 1'b0; in_instr = 16'($urandom);
         end
         #1;
         if (stalled_prev) check({name, "_stall_hold"}, pack_out(), snap);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check({name, "_unexpected_bundle"}, out_valid, 0);
            end else begin
               e = model(exp_q[0]);
               check({name, "_bundle"}, pack_out(), pack(e));
               if (!out_ready) check({name, "_stall_in_ready"}, in_ready, 0);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  if (!e.illegal) exp_issue++;
               end
            end
         end
         stalled_prev = out_valid && !out_ready;
         snap = pack_out();
         if (in_valid && in_ready) begin
            exp_q.push_back(src_q[idx]);
            idx++;
         end
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check({name, "_outstanding"}, 64'(src_q.size() - idx + exp_q.size()), 0);
      if (mode == 0) check({name, "_cycles"}, 64'(cyc), 8);
      #1;
      check({name, "_issue_count"}, issue_count, exp_issue[15:0]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      vec_t        sv;
      rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; out_ready = 1'b0;
      foreach (mnem[i]) mnem[i] = "";
      mnem[1] = "AND";  mnem[2] = "OR";   mnem[3] = "XOR";
      mnem[5] = "ADD";  mnem[6] = "ADDU"; mnem[7] = "ADDC";
      mnem[9] = "SUB";  mnem[10] = "SUBC"; mnem[11] = "CMP";
      mnem[13] = "MOV"; mnem[14] = "MUL";

      vecs[0] = '{16'hD214, mk(0, 16'h0004, 0, 1, 8'hD1, 4'h0, 4'h2, 16'h0014)};
      vecs[1] = '{16'h01E2, mk(0, 16'h0002, 1, 0, 8'h0E, 4'h2, 4'h1, 16'h0000)};
      vecs[2] = '{16'h53FF, mk(0, 16'h0008, 1, 1, 8'h5F, 4'h0, 4'h3, 16'hFFFF)};
      vecs[3] = '{16'h14FF, mk(0, 16'h0010, 0, 1, 8'h1F, 4'h0, 4'h4, 16'h00FF)};
      vecs[4] = '{16'hB503, mk(0, 16'h0000, 1, 1, 8'hB0, 4'h0, 4'h5, 16'h0003)};
      vecs[5] = '{16'h0B37, mk(0, 16'h0800, 0, 0, 8'h03, 4'h7, 4'hB, 16'h0000)};
      vecs[6] = '{16'h6A80, mk(0, 16'h0400, 1, 1, 8'h68, 4'h0, 4'hA, 16'h0080)};
      vecs[7] = '{16'h0FBC, mk(0, 16'h0000, 1, 0, 8'h0B, 4'hC, 4'hF, 16'h0000)};

      reset_dut();
      foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

      src_q = '{16'h01E2, 16'h53FF, 16'h14FF, 16'hB503};
      run_words(0, "stall_stream");

      // reset while a bundle is held discards it
      @(negedge clk);
      in_valid = 1'b1; in_instr = 16'h01E2; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("midrst_held", out_valid, 1);
      reset_dut();

`ifdef INSTR_DEC_SHIFT_EN
      sv = '{16'h811E, mk(0, 16'h0002, 0, 1, 8'h81, 4'h0, 4'h1, 16'hFFFE)};
      apply_vec(sv, "lshi");
`else
      sv = '{16'h811E, mk(1, 16'h0000, 0, 0, 8'h81, 4'hE, 4'h1, 16'h0000)};
      illegal_seq(sv.instr, "lshi_illegal");
      reset_dut();
`endif

      illegal_seq(16'h0004, "illegal");
      reset_dut();
      apply_vec(vecs[0], "movi_after_halt");

      src_q.delete();
      for (int n = 0; n < 150; n++) begin
         w = 16'($urandom);
         for (int t = 0; t < 64 && model(w).illegal; t++) w = 16'($urandom);
         if (model(w).illegal) w = 16'hD214;
         src_q.push_back(w);
      end
      run_words(1, "random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
